// File: rtl/mindy_pkg.sv
// Shared definitions for the packet header stamper: header field layout,
// default signature and FSM state type.
package mindy_pkg;

    localparam int unsigned DATA_W = 512;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4D494E44;

    localparam int unsigned MAGIC_LSB = 0;
    localparam int unsigned MAGIC_W   = 32;
    localparam int unsigned SID_LSB   = 32;
    localparam int unsigned SID_W     = 8;
    localparam int unsigned SEQ_LSB   = 40;
    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned SIZE_LSB  = 72;
    localparam int unsigned SIZE_W    = 16;
    localparam int unsigned BEATS_LSB = 88;
    localparam int unsigned BEATS_W   = 10;

    typedef enum logic {
        S_HEADER  = 1'b0,
        S_PAYLOAD = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] build_header(
        input logic [MAGIC_W-1:0] magic,
        input logic [SID_W-1:0]   stream_id,
        input logic [SEQ_W-1:0]   seq,
        input logic [SIZE_W-1:0]  size
    );
        logic [DATA_W-1:0] h;
        h = '0;
        h[MAGIC_LSB +: MAGIC_W] = magic;
        h[SID_LSB   +: SID_W]   = stream_id;
        h[SEQ_LSB   +: SEQ_W]   = seq;
        h[SIZE_LSB  +: SIZE_W]  = size;
        h[BEATS_LSB +: BEATS_W] = size[15:6];
        return h;
    endfunction

endpackage

// File: rtl/packet_header_stamper.sv
// Prepends a 64-byte header beat to every AXI-Stream packet and checks the
// payload beat count against PACKET_SIZE, publishing sent/error status.
module packet_header_stamper
    import mindy_pkg::*;
#(
    parameter logic [7:0]  STREAM_ID = 8'h00,
    parameter logic [31:0] MAGIC     = DEFAULT_MAGIC
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] AXIS_IN_TDATA,
    input  logic         AXIS_IN_TLAST,
    input  logic         AXIS_IN_TVALID,
    output logic         AXIS_IN_TREADY,
    output logic [511:0] AXIS_OUT_TDATA,
    output logic         AXIS_OUT_TLAST,
    output logic         AXIS_OUT_TVALID,
    input  logic         AXIS_OUT_TREADY,
    input  logic [15:0]  PACKET_SIZE,
    input  logic         SEQ_CLEAR,
    output logic [31:0]  PACKETS_SENT,
    output logic         LENGTH_ERROR
);

    state_e             state_q, state_d;
    logic [SEQ_W-1:0]   seq_num_q, seq_num_d;
    logic [SEQ_W-1:0]   hdr_seq_q, hdr_seq_d;
    logic [BEATS_W-1:0] beat_count_q, beat_count_d;
    logic [31:0]        packets_sent_q, packets_sent_d;
    logic               length_error_q, length_error_d;

    logic [BEATS_W-1:0] expected_beats;
    logic [BEATS_W-1:0] beat_num;
    logic               out_hs;

    assign expected_beats = PACKET_SIZE[15:6];
    // Output valid mirrors input valid in both states, so one handshake term serves both.
    assign out_hs         = AXIS_IN_TVALID && AXIS_OUT_TREADY;
    assign beat_num       = (beat_count_q == '1) ? beat_count_q : beat_count_q + 10'd1;

    always_comb begin
        state_d         = state_q;
        seq_num_d       = seq_num_q;
        hdr_seq_d       = hdr_seq_q;
        beat_count_d    = beat_count_q;
        packets_sent_d  = packets_sent_q;
        length_error_d  = length_error_q;

        AXIS_IN_TREADY  = 1'b0;
        AXIS_OUT_TVALID = AXIS_IN_TVALID;
        AXIS_OUT_TLAST  = 1'b0;
        AXIS_OUT_TDATA  = build_header(MAGIC, STREAM_ID, hdr_seq_q, PACKET_SIZE);

        case (state_q)
            S_HEADER: begin
                if (out_hs) begin
                    state_d      = S_PAYLOAD;
                    beat_count_d = '0;
                end
            end
            S_PAYLOAD: begin
                AXIS_IN_TREADY = AXIS_OUT_TREADY;
                AXIS_OUT_TLAST = AXIS_IN_TLAST;
                AXIS_OUT_TDATA = AXIS_IN_TDATA;
                if (out_hs) begin
                    beat_count_d = beat_num;
                    if ((expected_beats != '0) && (AXIS_IN_TLAST != (beat_num == expected_beats)))
                        length_error_d = 1'b1;
                    if (AXIS_IN_TLAST) begin
                        state_d        = S_HEADER;
                        seq_num_d      = seq_num_q + 32'd1;
                        packets_sent_d = packets_sent_q + 32'd1;
                        // Latch the next header's sequence now so later clears cannot disturb it.
                        hdr_seq_d      = SEQ_CLEAR ? '0 : seq_num_q + 32'd1;
                    end
                end
            end
            default: state_d = S_HEADER;
        endcase

        if (SEQ_CLEAR)
            seq_num_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_HEADER;
            seq_num_q      <= '0;
            hdr_seq_q      <= '0;
            beat_count_q   <= '0;
            packets_sent_q <= '0;
            length_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_num_q      <= seq_num_d;
            hdr_seq_q      <= hdr_seq_d;
            beat_count_q   <= beat_count_d;
            packets_sent_q <= packets_sent_d;
            length_error_q <= length_error_d;
        end
    end

    assign PACKETS_SENT = packets_sent_q;
    assign LENGTH_ERROR = length_error_q;

endmodule

// File: tb/tb_packet_header_stamper.sv
// Scoreboard bench for packet_header_stamper: driver queues expected beats,
// an independent monitor pops and compares on every output handshake.
module tb_packet_header_stamper;

    localparam logic [7:0]  SID = 8'h5A;
    localparam logic [31:0] MAG = 32'h4D494E44;

    logic         clk;
    logic         resetn;
    logic [511:0] AXIS_IN_TDATA;
    logic         AXIS_IN_TLAST;
    logic         AXIS_IN_TVALID;
    logic         AXIS_IN_TREADY;
    logic [511:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TLAST;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TREADY;
    logic [15:0]  PACKET_SIZE;
    logic         SEQ_CLEAR;
    logic [31:0]  PACKETS_SENT;
    logic         LENGTH_ERROR;

    packet_header_stamper #(.STREAM_ID(SID)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .AXIS_IN_TDATA   (AXIS_IN_TDATA),
        .AXIS_IN_TLAST   (AXIS_IN_TLAST),
        .AXIS_IN_TVALID  (AXIS_IN_TVALID),
        .AXIS_IN_TREADY  (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .PACKET_SIZE     (PACKET_SIZE),
        .SEQ_CLEAR       (SEQ_CLEAR),
        .PACKETS_SENT    (PACKETS_SENT),
        .LENGTH_ERROR    (LENGTH_ERROR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic         err;
        logic [31:0]  pkts;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    bit          rand_rdy   = 1'b0;
    logic [31:0] m_seq;
    logic [31:0] m_pkts;
    logic        m_err;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "run aborted");
    endtask

    initial begin
        #2_000_000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_now();
    end

    // Output ready: always 1, or a fair coin per cycle.
    initial begin
        AXIS_OUT_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            AXIS_OUT_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: post-handshake status checks, stall stability, data/last compare.
    initial begin
        exp_t         e;
        exp_t         post;
        bit           have_post;
        bit           prev_stall;
        logic [511:0] prev_data;
        have_post  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                have_post  = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            if (have_post) begin
                chk("length_error", {511'b0, LENGTH_ERROR}, {511'b0, post.err});
                chk("packets_sent", {480'b0, PACKETS_SENT}, {480'b0, post.pkts});
                have_post = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", {511'b0, AXIS_OUT_TVALID}, 512'd1);
                chk("stall_data", AXIS_OUT_TDATA, prev_data);
            end
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_beat: got data %0h required no beat", AXIS_OUT_TDATA);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", AXIS_OUT_TDATA, e.data);
                    chk("beat_tlast", {511'b0, AXIS_OUT_TLAST}, {511'b0, e.last});
                    post      = e;
                    have_post = 1'b1;
                end
            end
            prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
            prev_data  = AXIS_OUT_TDATA;
        end
    end

    task automatic do_reset();
        resetn         = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        AXIS_IN_TLAST  = 1'b0;
        SEQ_CLEAR      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        sb.delete();
        m_seq  = '0;
        m_pkts = '0;
        m_err  = 1'b0;
        @(negedge clk);
        chk("rst_in_tready", {511'b0, AXIS_IN_TREADY}, 512'd0);
        chk("rst_out_tvalid", {511'b0, AXIS_OUT_TVALID}, 512'd0);
        chk("rst_out_tlast", {511'b0, AXIS_OUT_TLAST}, 512'd0);
        chk("rst_packets_sent", {480'b0, PACKETS_SENT}, 512'd0);
        chk("rst_length_error", {511'b0, LENGTH_ERROR}, 512'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_hs();
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            @(negedge clk);
            done = AXIS_IN_TREADY;
            n++;
            if (!done && n > 1000) begin
                compared++;
                mismatched++;
                $display("FAIL input_handshake_timeout: got no handshake required one within 1000 cycles");
                finish_now();
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d beats outstanding required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Queue the whole expected packet, then drive it; abort_after>0 resets mid-payload.
    task automatic send_packet(input int len, input bit gaps, input bit clr, input int abort_after);
        logic [511:0] beats[$];
        logic [511:0] d;
        logic [15:0]  ps;
        exp_t         e;
        int           expb;
        int           err_beat;
        int           k;
        ps       = PACKET_SIZE;
        expb     = ps / 64;
        err_beat = (expb != 0 && len != expb) ? ((len < expb) ? len : expb) : 0;
        e.data = {414'b0, 10'(expb), ps, m_seq, SID, MAG};
        e.last = 1'b0;
        e.err  = m_err;
        e.pkts = m_pkts;
        sb.push_back(e);
        for (int i = 1; i <= len; i++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            beats.push_back(d);
            e.data = d;
            e.last = (i == len);
            e.err  = m_err || (err_beat != 0 && i >= err_beat);
            e.pkts = m_pkts + ((i == len) ? 1 : 0);
            sb.push_back(e);
        end
        m_err  = m_err || (err_beat != 0);
        m_pkts = m_pkts + 1;
        m_seq  = clr ? 32'd0 : m_seq + 1;

        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                k = $urandom_range(0, 2);
                AXIS_IN_TVALID = 1'b0;
                repeat (k) begin
                    @(posedge clk);
                    #1;
                end
            end
            AXIS_IN_TDATA  = beats[i];
            AXIS_IN_TLAST  = (i == len - 1);
            AXIS_IN_TVALID = 1'b1;
            SEQ_CLEAR      = clr && (i == len - 1);
            wait_hs();
            if (abort_after == i + 1) begin
                do_reset();
                return;
            end
        end
        AXIS_IN_TVALID = 1'b0;
        AXIS_IN_TLAST  = 1'b0;
        SEQ_CLEAR      = 1'b0;
    endtask

    initial begin
        int len;
        int pick;
        resetn         = 1'b0;
        AXIS_IN_TDATA  = '0;
        AXIS_IN_TLAST  = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        PACKET_SIZE    = 16'h0100;
        SEQ_CLEAR      = 1'b0;
        m_seq          = '0;
        m_pkts         = '0;
        m_err          = 1'b0;
        do_reset();

        // Three well-formed 4-beat packets.
        repeat (3) send_packet(4, 1'b0, 1'b0, 0);
        drain();
        chk("basic_packets_sent", {480'b0, PACKETS_SENT}, 512'd3);
        chk("basic_length_error", {511'b0, LENGTH_ERROR}, 512'd0);

        // Short packet sets the sticky error; next packet still stamped seq+1.
        send_packet(3, 1'b0, 1'b0, 0);
        send_packet(4, 1'b0, 1'b0, 0);
        drain();
        chk("short_error_sticky", {511'b0, LENGTH_ERROR}, 512'd1);

        // Long packet: error at beat 4, TLAST still follows the input on beat 6.
        do_reset();
        send_packet(6, 1'b0, 1'b0, 0);
        for (int s = 1; s < 7; s++) send_packet(4, 1'b0, 1'b0, 0);
        // Packet seq 7 ends with SEQ_CLEAR on its TLAST handshake.
        send_packet(4, 1'b0, 1'b1, 0);
        send_packet(4, 1'b0, 1'b0, 0);
        send_packet(4, 1'b0, 1'b0, 0);
        drain();

        // Reset in the middle of a payload, then a fresh packet.
        send_packet(4, 1'b0, 1'b0, 2);
        send_packet(4, 1'b0, 1'b0, 0);
        drain();
        chk("after_midreset_packets", {480'b0, PACKETS_SENT}, 512'd1);
        chk("after_midreset_error", {511'b0, LENGTH_ERROR}, 512'd0);

        // Randomised traffic with back-pressure and valid gaps.
        do_reset();
        rand_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len  = $urandom_range(1, 8);
            pick = $urandom_range(0, 19);
            if (pick < 14)
                PACKET_SIZE = 16'(len * 64 + $urandom_range(0, 63));
            else if (pick < 17)
                PACKET_SIZE = 16'($urandom_range(0, 63));
            else
                PACKET_SIZE = 16'($urandom_range(1, 8) * 64);
            send_packet(len, 1'b1, 1'b0, 0);
        end
        drain();
        rand_rdy = 1'b0;
        chk("random_packets_sent", {480'b0, PACKETS_SENT}, 512'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
